// File: rtl/dot_product_serial_mac.sv
// Element-serial multiply-accumulate engine: accumulates a*b over one vector of up to
// NUM_ELEMENTS beats and presents the unsigned dot product on a valid/ready result port.
module dot_product_serial_mac #(
  parameter int unsigned NUM_ELEMENTS  = 8,
  parameter int unsigned ELEMENT_WIDTH = 8,
  parameter int unsigned RESULT_WIDTH  = $clog2(NUM_ELEMENTS * (2 ** ELEMENT_WIDTH) ** 2),
  parameter int unsigned LEN_WIDTH     = $clog2(NUM_ELEMENTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ELEMENT_WIDTH-1:0] in_a,
  input  logic [ELEMENT_WIDTH-1:0] in_b,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RESULT_WIDTH-1:0]  out_result,
  output logic [LEN_WIDTH-1:0]     out_len,
  output logic                     out_trunc
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                     r_state;
  state_e                     w_state_next;
  logic [RESULT_WIDTH-1:0]    r_acc;
  logic [LEN_WIDTH-1:0]       r_cnt;
  logic [RESULT_WIDTH-1:0]    r_result;
  logic [LEN_WIDTH-1:0]       r_len;
  logic                       r_trunc;

  logic [2*ELEMENT_WIDTH-1:0] w_product;
  logic [RESULT_WIDTH-1:0]    w_product_ext;
  logic [RESULT_WIDTH-1:0]    w_sum;
  logic [LEN_WIDTH-1:0]       w_cnt_next;
  logic                       w_accept;
  logic                       w_close;
  logic                       w_result_taken;

  // Handshake flags are pure state decodes, so no input reaches them combinationally.
  assign in_ready  = (r_state != StDone);
  assign out_valid = (r_state == StDone);

  assign w_accept       = in_valid && in_ready;
  assign w_result_taken = out_valid && out_ready;

  // Operands widened first so the full 2*ELEMENT_WIDTH product is kept.
  assign w_product     = {{ELEMENT_WIDTH{1'b0}}, in_a} * {{ELEMENT_WIDTH{1'b0}}, in_b};
  assign w_product_ext = RESULT_WIDTH'(w_product);

  // The first beat of a vector loads the accumulator instead of adding to it.
  assign w_sum      = (r_state == StIdle) ? w_product_ext : (r_acc + w_product_ext);
  assign w_cnt_next = (r_state == StIdle) ? LEN_WIDTH'(1) : (r_cnt + LEN_WIDTH'(1));
  assign w_close    = w_accept && (in_last || (w_cnt_next == LEN_WIDTH'(NUM_ELEMENTS)));

  assign out_result = r_result;
  assign out_len    = r_len;
  assign out_trunc  = r_trunc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: accumulate until close, then hold the result until taken.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StAccum: begin
        if (w_accept) begin
          w_state_next = w_close ? StDone : StAccum;
        end
      end
      StDone: begin
        if (w_result_taken) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Accumulator, beat counter and registered result fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_len    <= '0;
      r_trunc  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_next;
        if (w_close) begin
          r_result <= w_sum;
          r_len    <= w_cnt_next;
          r_trunc  <= ~in_last;
        end
      end
      // Result and length stay visible after hand-off; only trunc is cleared.
      if (w_result_taken) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_trunc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_serial_mac.sv
// Scoreboard bench for dot_product_serial_mac: stimulus pushes reference results, a
// monitor pops and compares them on every result handshake.
module tb_dot_product_serial_mac;

  localparam int NE = 8;
  localparam int EW = 8;
  localparam int RW = 19;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_a;
  logic [EW-1:0] in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic [LW-1:0] out_len;
  logic          out_trunc;

  dot_product_serial_mac #(
    .NUM_ELEMENTS (NE),
    .ELEMENT_WIDTH(EW),
    .RESULT_WIDTH (RW),
    .LEN_WIDTH    (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_len   (out_len),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint res;
    longint len;
    bit     trunc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          rand_ready = 1'b0;
  int unsigned va[NE];
  int unsigned vb[NE];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with garbage on the don't-care data inputs.
  task automatic idle(input int k);
    repeat (k) begin
      in_valid = 1'b0;
      in_a     = EW'($urandom);
      in_b     = EW'($urandom);
      in_last  = 1'($urandom);
      step();
    end
  endtask

  // Present one beat and hold it until the engine accepts it.
  task automatic send_beat(input int unsigned a, input int unsigned b, input bit last);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_a     = EW'(a);
    in_b     = EW'(b);
    in_last  = last;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      t++;
      if (t > 500) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_accept_timeout: in_ready=%b, required 1", in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference: the dot product of the first L elements; trunc when no last was given.
  task automatic run_vector(input int L, input bit use_last, input bit gaps);
    exp_t   e;
    longint s;
    s = 0;
    for (int i = 0; i < L; i++) s += longint'(va[i]) * longint'(vb[i]);
    e.res   = s;
    e.len   = L;
    e.trunc = !use_last;
    q.push_back(e);
    for (int i = 0; i < L; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send_beat(va[i], vb[i], use_last && (i == L - 1));
    end
    check("result_latency", longint'(out_valid), 1);
  endtask

  // Randomised consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every result handshake pops and compares the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %0d, required no result", out_result);
        end else begin
          e = q.pop_front();
          check("sb_result", longint'(out_result), e.res);
          check("sb_len", longint'(out_len), e.len);
          check("sb_trunc", longint'(out_trunc), longint'(e.trunc));
        end
      end
    end
  end

  initial begin
    int c0;
    int t;
    exp_t e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_result", longint'(out_result), 0);
    check("rst_out_len", longint'(out_len), 0);
    check("rst_out_trunc", longint'(out_trunc), 0);
    rst = 1'b0;
    step();

    // Full-scale vector at one element per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < NE; i++) begin va[i] = 255; vb[i] = 255; end
    c0 = cyc;
    run_vector(8, 1'b1, 1'b0);
    check("full_throughput_cycles", longint'(cyc - c0), 8);
    check("full_result", longint'(out_result), 520200);

    // Short vector closed by in_last.
    va[0] = 2; va[1] = 3; va[2] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7;
    run_vector(3, 1'b1, 1'b0);
    check("short_result", longint'(out_result), 56);
    check("short_len", longint'(out_len), 3);

    // Ramp without last, consumer stalled, 9th beat offered while the result waits.
    step();
    out_ready = 1'b0;
    for (int i = 0; i < NE; i++) begin va[i] = i + 1; vb[i] = 1; end
    run_vector(8, 1'b0, 1'b0);
    e.res = 9; e.len = 1; e.trunc = 1'b0;
    q.push_back(e);
    in_valid = 1'b1;
    in_a     = 8'd9;
    in_b     = 8'd1;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_result", longint'(out_result), 36);
      check("bp_len", longint'(out_len), 8);
      check("bp_trunc", longint'(out_trunc), 1);
    end
    step();
    out_ready = 1'b1;
    step();
    check("post_hs_in_ready", longint'(in_ready), 1);
    check("post_hs_out_valid", longint'(out_valid), 0);
    check("post_hs_trunc_cleared", longint'(out_trunc), 0);
    check("post_hs_result_held", longint'(out_result), 36);
    check("post_hs_len_held", longint'(out_len), 8);
    step();
    in_valid = 1'b0;
    check("ninth_beat_valid", longint'(out_valid), 1);
    check("ninth_beat_result", longint'(out_result), 9);
    check("ninth_beat_len", longint'(out_len), 1);
    step();

    // Reset in the middle of a vector discards the partial sum.
    for (int i = 0; i < 4; i++) send_beat(10, 10, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", longint'(in_ready), 1);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_result", longint'(out_result), 0);
    check("mid_rst_len", longint'(out_len), 0);
    step();
    step();
    rst = 1'b0;
    step();
    va[0] = 3; va[1] = 3; vb[0] = 3; vb[1] = 3;
    run_vector(2, 1'b1, 1'b0);
    check("after_rst_result", longint'(out_result), 18);
    check("after_rst_len", longint'(out_len), 2);

    // Random vectors with input gaps and consumer backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      int  L;
      bit  use_last;
      L        = int'($urandom_range(1, NE));
      use_last = (L < NE) ? 1'b1 : ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NE; i++) begin
        va[i] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
        vb[i] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
      end
      run_vector(L, use_last, 1'b1);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    t = 0;
    while (q.size() > 0 && t < 100) begin
      step();
      t++;
    end
    check("queue_drained", longint'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
